// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation encoding, FSM states
// and operand-signedness helpers.
package muldiv_pkg;

  // Encoding follows the RV32M funct3 field so EX can pass it straight through.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdop_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_t;

  function automatic logic md_is_div(input mdop_t op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input mdop_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_a_signed(input mdop_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input mdop_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 step of the multiply/divide datapath on unsigned magnitudes.
// The restoring-divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   b_mag,
`ifdef MULDIV_DIV_EN
  input  logic                    div_mode,
`endif
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [W:0] div_shift;
  logic [W:0] div_diff;
`endif

  // Multiply keeps {partial_hi, multiplier_lo}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_next = {mul_sum, acc[W-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (div_mode) begin
      if (div_diff[W]) acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      else             acc_next = {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Division datapath and its fast paths are built only when MULDIV_DIV_EN is defined.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  mdop_t                 mdop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  md_state_t          state;
  mdop_t              op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*W-1:0]     acc;
  logic [W-1:0]       b_mag_q;
  logic [2*W-1:0]     acc_next;
  logic               sign_a;
  logic               sign_b;
  logic [W-1:0]       a_mag;
  logic [W-1:0]       b_mag;
  logic [2*W-1:0]     prod;
  logic [W-1:0]       fix_result;
`ifdef MULDIV_DIV_EN
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  logic               div_by_zero;
  logic               div_ovf;
  logic [W-1:0]       quo_mag;
  logic [W-1:0]       rem_mag;
`endif

  always_comb begin
    sign_a = md_a_signed(mdop) & opr_a[W-1];
    sign_b = md_b_signed(mdop) & opr_b[W-1];
    a_mag  = sign_a ? -opr_a : opr_a;
    b_mag  = sign_b ? -opr_b : opr_b;
`ifdef MULDIV_DIV_EN
    div_by_zero = (opr_b == '0);
    div_ovf     = ((mdop == MD_DIV) || (mdop == MD_REM)) && (opr_a == MOST_NEG) && (opr_b == '1);
`endif
  end

  muldiv_core #(.DATA_WIDTH(W)) u_core (
    .acc      (acc),
    .b_mag    (b_mag_q),
`ifdef MULDIV_DIV_EN
    .div_mode (md_is_div(op_q)),
`endif
    .acc_next (acc_next)
  );

  // Unsigned-op sign flags are latched as 0, so the XOR covers every case.
  always_comb begin
    prod       = (sign_a_q ^ sign_b_q) ? -acc : acc;
    fix_result = (op_q == MD_MUL) ? prod[W-1:0] : prod[2*W-1:W];
`ifdef MULDIV_DIV_EN
    quo_mag = acc[W-1:0];
    rem_mag = acc[2*W-1:W];
    if (md_is_div(op_q)) begin
      if (md_is_rem(op_q)) fix_result = sign_a_q ? -rem_mag : rem_mag;
      else                 fix_result = (sign_a_q ^ sign_b_q) ? -quo_mag : quo_mag;
    end
`endif
  end

  // Control FSM: flush overrides everything, including a start seen in IDLE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_IDLE;
      op_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      b_mag_q  <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q     <= mdop;
              sign_a_q <= sign_a;
              sign_b_q <= sign_b;
              cnt      <= '0;
              acc      <= {{W{1'b0}}, a_mag};
              b_mag_q  <= b_mag;
              busy     <= 1'b1;
              if (!md_is_div(mdop)) begin
                state <= ST_CALC;
`ifdef MULDIV_DIV_EN
              end else if (div_by_zero) begin
                result <= md_is_rem(mdop) ? opr_a : '1;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else if (div_ovf) begin
                result <= md_is_rem(mdop) ? '0 : MOST_NEG;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else begin
                state <= ST_CALC;
              end
`else
              end else begin
                result  <= '0;
                illegal <= 1'b1;
                done    <= 1'b1;
                state   <= ST_DONE;
              end
`endif
            end
          end
          ST_CALC: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= ST_FIX;
          end
          ST_FIX: begin
            result <= fix_result;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors push expectations, a monitor checks each done.
// Division vectors are selected by MULDIV_DIV_EN to match the build under test.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  mdop_t        mdop = MD_MUL;
  logic [W-1:0] opr_a = '0;
  logic [W-1:0] opr_b = '0;
  logic         busy;
  logic         done;
  logic         illegal;
  logic [W-1:0] result;

  int           checks = 0;
  int           errors = 0;
  int           cycle_cnt = 0;
  logic [W-1:0] last_result = '0;
  exp_t         sb[$];
  exp_t         mon_e;

  ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .start   (start),
    .mdop    (mdop),
    .opr_a   (opr_a),
    .opr_b   (opr_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (arst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cycle_cnt);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_illegal"}, W'(illegal), W'(mon_e.ill));
        check({mon_e.name, "_done_cycle"}, W'(cycle_cnt), W'(mon_e.cyc));
        check({mon_e.name, "_busy_at_done"}, W'(busy), W'(1));
      end
    end
  end

  task automatic check_output(input string name, input logic [W-1:0] exp_res);
    @(negedge clk);
    #1;
    check({name, "_busy_after"}, W'(busy), W'(0));
    check({name, "_done_after"}, W'(done), W'(0));
    check({name, "_result_held"}, result, exp_res);
    last_result = exp_res;
  endtask

  task automatic apply_stimulus(input mdop_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp_res, input logic exp_ill, input int lat,
                                input string name, input int poke = 0);
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    mdop  = op;
    opr_a = a;
    opr_b = b;
    start = 1'b1;
    sb.push_back('{res: exp_res, ill: exp_ill, cyc: cycle_cnt + lat, name: name});
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == poke) begin
        mdop  = MD_MULHU;
        opr_a = '1;
        opr_b = '1;
        start = 1'b1;
      end
      if (poke != 0 && k == poke + 1) start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done within 60 cycles, expected done at latency %0d", name, lat);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    if (lat > 1) check({name, "_busy_during"}, W'(busy_ok), W'(1));
    check_output(name, exp_res);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_illegal", W'(illegal), W'(0));
    check("reset_result", result, '0);
    @(negedge clk);
    arst_n = 1'b1;

    apply_stimulus(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34, "mul_7_m3");
    apply_stimulus(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34, "mulh_minmin");
    apply_stimulus(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, "mulhu_maxmax");
    apply_stimulus(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, "mulhsu_m1");
    apply_stimulus(MD_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, "mulh_7_m3");
    apply_stimulus(MD_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 34, "mulhu_2p32");

`ifdef MULDIV_DIV_EN
    apply_stimulus(MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34, "div_m7_2");
    apply_stimulus(MD_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34, "rem_m7_2");
    apply_stimulus(MD_DIVU, 32'hFFFFFFFE, 32'd3,        32'h55555554, 1'b0, 34, "divu_big_3");
    apply_stimulus(MD_REMU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 1'b0, 34, "remu_big_3");
    apply_stimulus(MD_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 34, "div_100_m7");
    apply_stimulus(MD_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0, 34, "rem_m100_7");
    apply_stimulus(MD_DIV,  32'd1234,     32'd0,        32'hFFFFFFFF, 1'b0, 1,  "div_by_zero");
    apply_stimulus(MD_REMU, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1,  "remu_by_zero");
    apply_stimulus(MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1,  "div_overflow");
    apply_stimulus(MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1,  "rem_overflow");
    apply_stimulus(MD_DIVU, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 1,  "divu_by_zero");
`else
    apply_stimulus(MD_REM,  32'hFFFFFFF9, 32'd2,        32'h00000000, 1'b1, 1,  "rem_illegal");
    apply_stimulus(MD_DIVU, 32'hFFFFFFFE, 32'd3,        32'h00000000, 1'b1, 1,  "divu_illegal");
`endif
    apply_stimulus(MD_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 34, "mul_3_5");

    // A second start mid-operation must be ignored: one done, original result.
    apply_stimulus(MD_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 34, "start_ignored", 5);

    // Flush in cycle 10: idle in cycle 11, no done, result untouched.
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    mdop = MD_DIV;
`else
    mdop = MD_MUL;
`endif
    opr_a = 32'd1000;
    opr_b = 32'd7;
    start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) flush = 1'b1;
      if (k == 11) flush = 1'b0;
    end
    #1;
    check("flush_busy", W'(busy), W'(0));
    repeat (40) @(negedge clk);
    #1;
    check("flush_result_held", result, last_result);

    // Asynchronous reset in cycle 5 of a multiply clears outputs immediately.
    @(negedge clk);
    mdop  = MD_MUL;
    opr_a = 32'd9;
    opr_b = 32'd9;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    #1;
    check("pre_reset_busy", W'(busy), W'(1));
    arst_n = 1'b0;
    #1;
    check("async_reset_busy", W'(busy), W'(0));
    check("async_reset_done", W'(done), W'(0));
    check("async_reset_illegal", W'(illegal), W'(0));
    check("async_reset_result", result, '0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("post_reset_idle", W'(busy), W'(0));

    apply_stimulus(MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 34, "mul_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
